// File: rtl/fb_pixel_fetch.sv
// rtl/fb_pixel_fetch.sv - raster-tracking framebuffer read stage producing aligned greyscale pixels
// Address = frame base + line accumulator + column; sync/DE delayed to match framebuffer latency.
module fb_pixel_fetch #(
  parameter int          IMG_W   = 256,
  parameter int          IMG_H   = 256,
  parameter int          MEM_LAT = 2,
  parameter logic [23:0] BORDER  = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_de,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic [17:0] offset,
  output logic [17:0] parallelAddress,
  input  logic [7:0]  q,
  output logic [23:0] color,
  output logic        pix_de,
  output logic        pix_hs,
  output logic        pix_vs
);

  localparam logic [11:0] W12 = 12'(IMG_W);
  localparam logic [11:0] H12 = 12'(IMG_H);
  localparam logic [17:0] W18 = 18'(IMG_W);

  logic        de_q, vs_q, skip;
  logic [11:0] x, y;
  logic [17:0] off_l, line_acc, row_base;
  logic        de_eff, de_fall, vs_rise, in_img;
  logic [3:0]  dly [0:MEM_LAT];
  logic        in_img_d, de_d, hs_d, vs_d;

  // After a reset the rest of the current DE burst is ignored so it is not counted as a line.
  assign de_eff   = vid_de & ~skip;
  assign de_fall  = de_q & ~de_eff;
  assign vs_rise  = vid_vs & ~vs_q;
  assign in_img   = de_eff & (x < W12) & (y < H12);
  assign row_base = off_l + line_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q            <= 1'b0;
      vs_q            <= 1'b0;
      skip            <= 1'b1;
      x               <= 12'd0;
      y               <= 12'd0;
      off_l           <= 18'd0;
      line_acc        <= 18'd0;
      parallelAddress <= 18'd0;
    end else begin
      de_q <= de_eff;
      vs_q <= vid_vs;
      if (!vid_de)
        skip <= 1'b0;
      if (de_eff)
        x <= (x == 12'hFFF) ? x : x + 12'd1;
      else
        x <= 12'd0;
      // VS rise takes priority over a coincident DE fall
      if (vs_rise) begin
        y        <= 12'd0;
        off_l    <= offset;
        line_acc <= 18'd0;
      end else if (de_fall) begin
        y        <= (y == 12'hFFF) ? y : y + 12'd1;
        line_acc <= line_acc + W18;
      end
      if (in_img)
        parallelAddress <= row_base + {6'd0, x};
    end
  end

  assign {in_img_d, de_d, hs_d, vs_d} = dly[MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MEM_LAT; i++)
        dly[i] <= 4'b0;
      color  <= 24'h0;
      pix_de <= 1'b0;
      pix_hs <= 1'b0;
      pix_vs <= 1'b0;
    end else begin
      dly[0] <= {in_img, de_eff, vid_hs, vid_vs};
      for (int i = 1; i <= MEM_LAT; i++)
        dly[i] <= dly[i-1];
      if (in_img_d)
        color <= {q, q, q};
      else if (de_d)
        color <= BORDER;
      else
        color <= 24'h0;
      pix_de <= de_d;
      pix_hs <= hs_d;
      pix_vs <= vs_d;
    end
  end

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// tb/tb_fb_pixel_fetch.sv - randomized directed bench for fb_pixel_fetch with a raster-level model
// Expected pixels come from line/column arithmetic (base + line*W + col), queued by due cycle.
module tb_fb_pixel_fetch;

  localparam int          W   = 256;
  localparam int          H   = 256;
  localparam int          LAT = 2;
  localparam logic [23:0] BRD = 24'h5A3C96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
  logic [17:0] offset = 18'd0;
  logic [17:0] parallelAddress;
  logic [7:0]  mem_q, mem_p1;
  logic [23:0] color;
  logic        pix_de, pix_hs, pix_vs;

  fb_pixel_fetch #(.IMG_W(W), .IMG_H(H), .MEM_LAT(LAT), .BORDER(BRD)) dut (
    .clk(clk), .rst(rst), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .offset(offset), .parallelAddress(parallelAddress), .q(mem_q),
    .color(color), .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs)
  );

  always #5 clk = ~clk;

  // framebuffer with 2-cycle read latency, q = addr[7:0]
  always @(posedge clk) begin
    mem_p1 <= parallelAddress[7:0];
    mem_q  <= mem_p1;
  end

  typedef struct {
    int          due;
    logic [23:0] color;
    logic        de, hs, vs;
  } exp_t;

  exp_t        eq[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [17:0] exp_addr = 18'd0;
  int          m_line = 0, m_col = 0, m_base = 0;
  logic        m_prev_de = 1'b0, m_prev_vs = 1'b0, m_drop = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    eq.delete();
    for (int i = 1; i <= 4; i++) begin
      z.due = cyc + i; z.color = 24'h0; z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0;
      eq.push_back(z);
    end
    exp_addr = 18'd0;
    m_line = 0; m_col = 0; m_base = 0;
    m_prev_de = 1'b0; m_prev_vs = 1'b0; m_drop = 1'b1;
  endtask

  task automatic step(input logic de, input logic hs, input logic vs, input logic r);
    exp_t e;
    logic de_e, vs_rise, de_fall, inimg;
    @(negedge clk);
    cyc++;
    if (eq.size() > 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      chk("color", color, e.color);
      chk("pix_de", pix_de, e.de);
      chk("pix_hs", pix_hs, e.hs);
      chk("pix_vs", pix_vs, e.vs);
    end
    chk("addr", parallelAddress, exp_addr);
    vid_de = de; vid_hs = hs; vid_vs = vs; rst = r;
    if (r) begin
      model_reset();
    end else begin
      de_e = de && !m_drop;
      if (!de) m_drop = 1'b0;
      vs_rise = vs && !m_prev_vs;
      de_fall = m_prev_de && !de_e;
      inimg   = de_e && (m_col < W) && (m_line < H);
      if (inimg) exp_addr = 18'(m_base + m_line * W + m_col);
      e.due   = cyc + 4;
      e.color = inimg ? {3{exp_addr[7:0]}} : (de_e ? BRD : 24'h0);
      e.de = de_e; e.hs = hs; e.vs = vs;
      eq.push_back(e);
      if (vs_rise) begin
        m_line = 0; m_base = int'(offset);
      end else if (de_fall) begin
        m_line++;
      end
      m_col = de_e ? m_col + 1 : 0;
      m_prev_de = de_e; m_prev_vs = vs;
    end
  endtask

  task automatic line(input int n, input int blank);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < blank; i++) step(1'b0, 1'(i < 2), 1'b0, 1'b0);
  endtask

  task automatic vsync();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // frame start: 300-pixel line, 44 border pixels at the end
    offset = 18'd0;
    vsync();
    line(300, 10);
    chk("addr_line0_end", parallelAddress, 32'd255);

    // random lines with offset changed mid-frame (no effect until next VS)
    for (int k = 0; k < 4; k++) begin
      offset = 18'($urandom);
      line($urandom_range(1, 300), $urandom_range(2, 8));
    end

    // scroll latch
    offset = 18'h100;
    vsync();
    line(20, 4);
    line(20, 4);
    chk("addr_scroll_line1", parallelAddress, 32'h213);

    // wrap-around
    offset = 18'h3FF80;
    vsync();
    line(200, 4);

    // VS rise coinciding with DE fall
    offset = 18'($urandom);
    line(30, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    line(20, 4);
    chk("addr_sim_vs", parallelAddress, 32'(18'(offset + 18'd19)));

    // line limit: rows 256..259 are border, address frozen at row 255 col 255
    offset = 18'd0;
    vsync();
    for (int i = 0; i < 260; i++) line((i >= 255) ? 260 : 4, 3);
    chk("addr_freeze", parallelAddress, 32'(255 * 256 + 255));

    // reset mid-line
    vsync();
    line(3, 4);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    line(20, 4);
    chk("addr_after_reset", parallelAddress, 32'd19);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
